// File: rtl/bcd_alu_sequencer.sv
// bcd_alu_sequencer
//   Multi-cycle packed-BCD arithmetic controller. One shared digit-serial
//   BCD adder/subtractor handles one digit per clock, least significant digit
//   first. Multiply is repeated addition and divide is repeated subtraction.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, op       request (sampled in IDLE only) and operation
//                   (00 add, 01 sub, 10 mul, 11 div)
//   a_bcd, b_bcd    packed-BCD operands, W = 4*DIGITS bits
//   busy            high from the start-accept edge until DONE is left
//   done            one-cycle pulse; result and flags are valid
//   result          packed-BCD magnitude
//   neg, ovf, err   negative subtract result, overflow, divide-by-zero or
//                   non-BCD operand
//
// Handshake: start is honoured only in IDLE. The accepting edge raises busy.
// done pulses for exactly one cycle while busy is still high. result and the
// flags then hold until the next start is accepted.
module bcd_alu_sequencer #(
    parameter int DIGITS = 4,
    localparam int W = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_bcd,
    input  logic [W-1:0] b_bcd,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         neg,
    output logic         ovf,
    output logic         err
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_RUN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    // acc: running sum (add/sub/mul) or remainder (div).
    // cnt: remaining multiplier (mul) or quotient so far (div).
    logic [W-1:0]   acc_q, acc_d, cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   result_q, result_d;
    logic           neg_q, neg_d, ovf_q, ovf_d, err_q, err_d;

    function automatic logic has_non_bcd(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Shared digit unit. acc is shifted right one digit per RUN cycle, so its
    // current digit is always acc_q[3:0]; after DIGITS cycles the new value
    // sits back in place. Mul adds A, everything else works against B.
    logic [W-1:0] y_vec;
    logic [3:0]   x_dig, y_dig, out_dig;
    logic [4:0]   sum5, diff5;
    logic         is_sub, cout, last_dig;
    logic [W-1:0] acc_shift;

    always_comb begin
        y_vec    = (op_q == OP_MUL) ? a_q : b_q;
        x_dig    = acc_q[3:0];
        y_dig    = y_vec[int'(idx_q)*4 +: 4];
        is_sub   = (op_q == OP_SUB) || (op_q == OP_DIV);
        sum5     = {1'b0, x_dig} + {1'b0, y_dig} + {4'b0, carry_q};
        diff5    = {1'b0, x_dig} - {1'b0, y_dig} - {4'b0, carry_q};
        out_dig  = sum5[3:0];
        cout     = 1'b0;
        if (is_sub) begin
            out_dig = diff5[3:0];
            if (diff5[4]) begin
                out_dig = diff5[3:0] + 4'd10;
                cout    = 1'b1;
            end
        end else if (sum5 > 5'd9) begin
            out_dig = sum5[3:0] + 4'd6;
            cout    = 1'b1;
        end
        acc_shift = {out_dig, acc_q[W-1:4]};
        last_dig  = (idx_q == IW'(DIGITS - 1));
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a_bcd;
                    b_d      = b_bcd;
                    op_d     = op;
                    result_d = '0;
                    neg_d    = 1'b0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                carry_d = 1'b0;
                if (has_non_bcd(a_q) || has_non_bcd(b_q) ||
                    (op_q == OP_DIV && b_q == '0)) begin
                    err_d    = 1'b0 | 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    case (op_q)
                        OP_ADD: begin
                            acc_d   = a_q;
                            state_d = S_RUN;
                        end
                        OP_SUB: begin
                            // Valid BCD compares like unsigned binary.
                            if (a_q < b_q) begin
                                acc_d = b_q;
                                a_d   = b_q;
                                b_d   = a_q;
                                neg_d = 1'b1;
                            end else begin
                                acc_d = a_q;
                            end
                            state_d = S_RUN;
                        end
                        OP_MUL: begin
                            acc_d   = '0;
                            cnt_d   = b_q;
                            state_d = S_CHECK;
                        end
                        default: begin
                            acc_d   = a_q;
                            cnt_d   = '0;
                            state_d = S_CHECK;
                        end
                    endcase
                end
            end
            S_RUN: begin
                acc_d   = acc_shift;
                carry_d = cout;
                idx_d   = idx_q + 1'b1;
                if (last_dig) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            result_d = acc_shift;
                            ovf_d    = cout;
                            state_d  = S_DONE;
                        end
                        OP_MUL: begin
                            if (cout) begin
                                ovf_d    = 1'b1;
                                result_d = {DIGITS{4'h9}};
                                state_d  = S_DONE;
                            end else begin
                                cnt_d   = bcd_dec(cnt_q);
                                state_d = S_CHECK;
                            end
                        end
                        default: begin
                            cnt_d   = bcd_inc(cnt_q);
                            state_d = S_CHECK;
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (op_q == OP_MUL) begin
                    if (cnt_q == '0) begin
                        result_d = acc_q;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    if (acc_q < b_q) begin
                        result_d = cnt_q;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign neg    = neg_q;
    assign ovf    = ovf_q;
    assign err    = err_q;
endmodule

// File: tb/tb_bcd_alu_sequencer.sv
// Testbench for bcd_alu_sequencer: directed cases plus randomized operations
// checked against a decimal-arithmetic reference model.
module tb_bcd_alu_sequencer;
    localparam int DIGITS = 4;
    localparam int W = 16;
    localparam int EDGE_BUDGET = 3000;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a_bcd = '0;
    logic [W-1:0] b_bcd = '0;
    logic         busy, done, neg, ovf, err;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    bcd_alu_sequencer #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_bcd(a_bcd), .b_bcd(b_bcd),
        .busy(busy), .done(done), .result(result),
        .neg(neg), .ovf(ovf), .err(err)
    );

    int n_tests = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] o,
                         output logic [W-1:0] r, output logic n, output logic ov,
                         output logic e, output int lat);
        int ai, bi, acc;
        r = '0; n = 1'b0; ov = 1'b0; e = 1'b0; lat = 1;
        if (!is_bcd(a) || !is_bcd(b)) begin
            e = 1'b1;
            return;
        end
        ai = bcd2int(a);
        bi = bcd2int(b);
        case (o)
            2'b00: begin
                acc = ai + bi;
                ov = (acc > 9999);
                r = int2bcd(acc % 10000);
                lat = 5;
            end
            2'b01: begin
                n = (ai < bi);
                r = int2bcd(n ? bi - ai : ai - bi);
                lat = 5;
            end
            2'b10: begin
                acc = 0;
                lat = 2;
                for (int k = 1; k <= bi; k++) begin
                    acc = acc + ai;
                    if (acc > 9999) begin
                        ov = 1'b1;
                        lat = 5 * k + 1;   // aborts on the last digit of pass k
                        break;
                    end
                    lat = 2 + 5 * k;
                end
                r = ov ? 16'h9999 : int2bcd(acc);
            end
            default: begin
                if (bi == 0) begin
                    e = 1'b1;
                end else begin
                    r = int2bcd(ai / bi);
                    lat = 2 + 5 * (ai / bi);
                end
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] o);
        logic [W-1:0] er;
        logic en, eov, ee;
        int elat, n, busy_bad;
        model(a, b, o, er, en, eov, ee, elat);
        exp_q.push_back(er);
        @(negedge clk);
        a_bcd = a; b_bcd = b; op = o; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        busy_bad = busy ? 0 : 1;
        while (!done && n < EDGE_BUDGET) begin
            @(posedge clk);
            #1;
            n++;
            if (!busy) busy_bad++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(elat));
        er = exp_q.pop_front();
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_neg"}, 32'(neg), 32'(en));
        check({tag, "_ovf"}, 32'(ovf), 32'(eov));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(result), 32'(er));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] ra, rb, wrap_res;
        logic [1:0] ro;
        logic wrap_ovf;
        int q, bv, done_cnt;

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", {29'd0, neg, ovf, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add", 16'h1234, 16'h0987, 2'b00);
        run_op("sub_neg", 16'h0100, 16'h0250, 2'b01);
        run_op("sub_eq", 16'h0042, 16'h0042, 2'b01);
        run_op("mul", 16'h0012, 16'h0003, 2'b10);
        run_op("mul_b0", 16'h0012, 16'h0000, 2'b10);
        run_op("mul_ovf", 16'h5000, 16'h0003, 2'b10);
        run_op("div", 16'h0100, 16'h0007, 2'b11);
        run_op("div_zero", 16'h0100, 16'h0000, 2'b11);
        run_op("non_bcd", 16'h00A5, 16'h0003, 2'b11);
        run_op("add_max", 16'h9999, 16'h9999, 2'b00);

        // Add wrap with a stray start pulse mid-operation.
        @(negedge clk);
        a_bcd = 16'h9999; b_bcd = 16'h0001; op = 2'b00; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        wrap_res = 16'hFFFF;
        wrap_ovf = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) begin
                @(negedge clk);
                a_bcd = 16'h1111; b_bcd = 16'h1111; op = 2'b10; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                wrap_res = result;
                wrap_ovf = ovf;
            end
        end
        check("wrap_result", 32'(wrap_res), 32'h0000);
        check("wrap_ovf", 32'(wrap_ovf), 32'd1);
        check("wrap_one_done", 32'(done_cnt), 32'd1);

        // Asynchronous reset during a long multiply.
        @(negedge clk);
        a_bcd = 16'h0001; b_bcd = 16'h0050; op = 2'b10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_done", 32'(done), 32'd0);
        check("rst_async_result", 32'(result), 32'd0);
        check("rst_async_flags", {29'd0, neg, ovf, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst", 16'h0007, 16'h0006, 2'b10);

        // Randomized operations with bounded iteration counts.
        for (int t = 0; t < 60; t++) begin
            ro = 2'($urandom_range(0, 3));
            ra = int2bcd($urandom_range(0, 9999));
            rb = int2bcd($urandom_range(0, 9999));
            if (ro == 2'b10) begin
                rb = int2bcd($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) ra = int2bcd($urandom_range(500, 9999));
                else ra = int2bcd($urandom_range(0, 600));
            end else if (ro == 2'b11) begin
                bv = $urandom_range(0, 400);
                q = $urandom_range(0, 15);
                rb = int2bcd(bv);
                ra = int2bcd((bv * q + $urandom_range(0, (bv > 0) ? bv - 1 : 20)) % 10000);
            end
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) ra[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
                else rb[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            run_op($sformatf("rand%0d_op%0d", t, ro), ra, rb, ro);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_alu_sequencer.md
Name: bcd_alu_sequencer

Overview:
- Multi-cycle controller for the calculator's 4-digit packed-BCD arithmetic. It sits between the entry FSM and the display.
- Accepts operands and a 2-bit operation code with a start/busy/done handshake.
- Sequences a single shared digit-serial BCD adder/subtractor one digit per clock. Multiply is done by repeated addition, divide by repeated subtraction.
- Returns a BCD result with sign, overflow and error flags.

Parameters:
- DIGITS, 4, number of BCD digits per operand/result; operand width W = 4*DIGITS.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 add, 01 sub, 10 mul, 11 div.
- a_bcd  input  W  operand A (num1), packed BCD.
- b_bcd  input  W  operand B (num2), packed BCD.
- busy  output  1  high from the start-accept edge until DONE is left.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  W  packed BCD result (magnitude).
- neg  output  1  sub result negative.
- ovf  output  1  result exceeded 10^DIGITS-1.
- err  output  1  divide by zero or non-BCD operand digit.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE.
  - busy, done, neg, ovf, err = 0; result = 0; internal accumulators and counters = 0.
- States: IDLE, LOAD, CHECK, RUN, DONE.
- IDLE:
  - start=1 at edge E0 latches a_bcd, b_bcd and op.
  - The same edge clears result and all flags, sets busy=1, and moves to LOAD.
  - start while busy is ignored; there is no queueing.
- LOAD (one cycle):
  - Any operand nibble >9 → err=1, result=0, go to DONE (latency 1: done high after E1).
  - div with B=0 → err=1, result=0, go to DONE.
  - sub with A<B → swap operands, neg=1.
  - add/sub → RUN with acc=A.
  - mul → CHECK with acc=0, cnt=B.
  - div → CHECK with rem=A, quo=0.
- RUN (exactly DIGITS cycles):
  - Processes digit i=0..DIGITS-1, LSD first, through one BCD digit adder (add: x+y+c, +6 correction; sub: x-y-borrow, +10 correction).
  - Carry/borrow is held in a 1-bit register between digits.
  - On the last digit:
    - add/sub: go to DONE. Final carry out → ovf=1, result keeps the low W bits (wrap).
    - mul: acc=acc+A, cnt=cnt-1 (BCD decrement), go to CHECK. Carry out → ovf=1, result=all-9s (16'h9999), abort to DONE.
    - div: rem=rem-B, quo=quo+1 (BCD increment), go to CHECK.
- CHECK (one cycle):
  - mul: cnt==0 → result=acc, go to DONE; else go to RUN.
  - div: rem<B → result=quo, go to DONE (remainder discarded); else go to RUN.
- DONE (one cycle): done=1, busy=1. Next edge → IDLE, busy=0.
- Output hold: result and flags hold their values until the next start is accepted.
- Latency, counted in edges from E0 to the edge that raises done:
  - add/sub: 5 (LOAD, 4×RUN).
  - mul: 2+5*B.
  - div: 2+5*Q.
  - error: 1.
- Compare rule: a BCD magnitude compare equals an unsigned compare of the packed vectors (valid after the LOAD check).
- start held high continuously: a new operation begins on the first IDLE edge after DONE.

Test Plan:
1. Add: op=00, A=16'h1234, B=16'h0987 → done 5 edges after E0, result=16'h2221, neg=ovf=err=0; busy high for 6 cycles.
2. Sub: op=01, A=16'h0100, B=16'h0250 → result=16'h0150, neg=1. A=B=16'h0042 → result=16'h0000, neg=0.
3. Mul: op=10, A=16'h0012, B=16'h0003 → result=16'h0036, latency 17. B=16'h0000 → result=0, latency 2. A=16'h5000, B=16'h0003 → ovf=1, result=16'h9999.
4. Div: op=11, A=16'h0100, B=16'h0007 → result=16'h0014, latency 72. B=0 → err=1, result=0, latency 1. A=16'h00A5 → err=1.
5. Add wrap: A=16'h9999, B=16'h0001 → result=16'h0000, ovf=1. A start pulse during that operation is ignored, so exactly one done pulse is produced.
6. Reset mid-mul (A=16'h0001, B=16'h0050, rst at edge 30) → busy, done, result and flags are 0 immediately without waiting for clk. The next start runs normally.
